ad7386_capture_sched: RTL and testbench
=======================================

// Module: ad7386_capture_sched
// PURPOSE
//  Scheduler/controller for the AD7386 SDOA frame engine; it sequences that engine.
//  Issues conversion requests at a programmable rate and counts burst or continuous captures.
//  Buffers returned samples in a small FIFO, tags the end of a burst with TLAST, and detects overruns.
//  Position: between the ADC frame engine (s_axis) and the RX FIR / AXIS switch (m_axis).
// PARAMETERS
//  DATA_W     16   sample width
//  CNT_W      16   width of rate divider, burst length and status counters
//  MIN_DIV    100  minimum clk cycles per conversion (1.0 MSPS @ 100 MHz)
//  FIFO_DEPTH 4    output FIFO entries; power of 2, >= 2
// PORTS
//  clk            in  1       100 MHz fabric clock
//  rst_n          in  1       async active-low reset
//  cmd_start      in  1       1-cycle pulse: begin capture
//  cmd_stop       in  1       1-cycle pulse: abort capture
//  cfg_rate_div   in  CNT_W   clk cycles per conversion; values < MIN_DIV are clamped to MIN_DIV
//  cfg_burst_len  in  CNT_W   samples per burst; 0 = continuous
//  conv_req       out 1       1-cycle pulse to the frame engine: start one conversion
//  conv_busy      in  1       frame engine has a conversion/frame in flight
//  s_axis_tdata   in  DATA_W  sample from the frame engine
//  s_axis_tvalid  in  1
//  s_axis_tready  out 1       = FIFO not full
//  m_axis_tdata   out DATA_W
//  m_axis_tvalid  out 1
//  m_axis_tlast   out 1       high on the final sample of a completed burst only
//  m_axis_tready  in  1
//  running        out 1       state != IDLE
//  done           out 1       1-cycle pulse on return to IDLE
//  sample_cnt     out CNT_W   samples accepted on s_axis since the last start
//  overrun_cnt    out CNT_W   skipped triggers since the last start; saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State returns to IDLE; FIFO is emptied.
//   - All outputs go to 0; s_axis_tready is 1.
//   - Applies at any point mid-operation; a partially read sample on s_axis is discarded.
//  cfg_* sampling:
//   - cfg_* are latched on an accepted cmd_start.
//   - cfg_* changes during a run are ignored.
//  Rate counter:
//   - Loaded with 0 on start, so the first trigger fires on the cycle after cmd_start.
//   - Reloaded with eff_div-1 on each trigger cycle; decrements otherwise.
//   - eff_div = max(cfg_rate_div, MIN_DIV).
//  Trigger cycle (counter==0 in RUN):
//   - If conv_busy=0 and the FIFO is not full: pulse conv_req and increment issued.
//   - Otherwise: no conv_req and overrun_cnt++. The slot is lost and the rate grid is kept.
//  Input side:
//   - An s_axis handshake pushes {last_tag, tdata} into the FIFO and increments sample_cnt.
//   - last_tag = (burst_len!=0 && sample_cnt+1==burst_len).
//  Output side:
//   - FIFO is first-word-fall-through: m_axis_tvalid rises 1 cycle after the s_axis handshake.
//   - Standard AXIS hold: tdata/tlast stay stable while tvalid=1 and tready=0.
//   - Simultaneous push and pop when full is not allowed, because tready=0 when full.
//   - Simultaneous push and pop when not full is allowed.
//  FSM:
//   - IDLE:
//     - cmd_start (with no cmd_stop) -> RUN.
//     - On entry to RUN: clear counters, latch cfg_*, load rate counter with 0.
//   - RUN:
//     - Issue triggers as above.
//     - When burst_len!=0 and issued==burst_len, stop triggering -> DRAIN.
//     - cmd_stop -> DRAIN; no further conv_req, including on that same cycle.
//     - cmd_start is ignored.
//   - DRAIN:
//     - Wait until conv_busy=0, no s_axis_tvalid is pending, and the FIFO is empty (last m_axis pop done).
//     - Then -> IDLE with a done pulse on that transition cycle.
//     - cmd_start and cmd_stop are ignored.
//  Simultaneous start+stop in IDLE: stop wins and the FSM stays IDLE.
//  Stopped runs: a run ended by cmd_stop ends without TLAST. Continuous mode never asserts TLAST.
//  Width rules:
//   - Counters are CNT_W unsigned and wrap, except overrun_cnt, which saturates.
//   - FIFO pointers are log2(FIFO_DEPTH)+1 bits; full = MSBs differ and LSBs equal.
// STRUCTURE
//  - Shared package ad7386_pkg: state encodings ST_IDLE/ST_RUN/ST_DRAIN, MIN_DIV default, DATA_W.
//  - Sub-module: axis_fwft_fifo. It holds DATA_W+1 bits (tag + data), FIFO_DEPTH entries, and provides full/empty.
//  - FSM, rate counter and status counters stay in this module.
// TESTING
//  1. Burst: div=100, burst=8, ideal engine, tready=1.
//     - conv_req pulses at cycles 1, 101, ..., 701 after start.
//     - 8 samples out; TLAST on the 8th only; done pulses once; sample_cnt=8.
//  2. Clamp: div=20, burst=3 -> conv_req spacing is exactly 100 cycles.
//  3. Backpressure: burst=10, m_axis_tready=0.
//     - After 4 samples the FIFO is full and s_axis_tready=0.
//     - Further trigger slots are skipped, so overrun_cnt increments.
//     - Release tready -> 4 samples drain, then the run completes.
//  4. Busy engine: hold conv_busy=1 for 250 cycles at div=100 -> 3 skipped slots, overrun_cnt=3, no conv_req during that window.
//  5. Stop: continuous, cmd_stop mid-frame.
//     - No conv_req after the stop.
//     - The in-flight sample is still delivered with tlast=0.
//     - done pulses after the FIFO empties.
//  6. Reset mid-RUN with 2 samples queued -> next cycle: running=0, m_axis_tvalid=0, counters=0, s_axis_tready=1.

Source files
------------

// File: rtl/ad7386_pkg.sv
// Shared types and default parameters for the AD7386 capture scheduler.
`timescale 1ns/1ps
package ad7386_pkg;

    localparam int DEFAULT_DATA_W     = 16;
    localparam int DEFAULT_CNT_W      = 16;
    localparam int DEFAULT_MIN_DIV    = 100;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ad7386_capture_sched_if.sv
// Conversion handshake plus the input/output sample streams of the capture scheduler.
`timescale 1ns/1ps
interface ad7386_capture_sched_if #(
    parameter int DATA_W = 16
);
    logic              conv_req;
    logic              conv_busy;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;

    modport master (
        output conv_req, s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  conv_busy, s_axis_tdata, s_axis_tvalid, m_axis_tready
    );

    modport slave (
        input  conv_req, s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output conv_busy, s_axis_tdata, s_axis_tvalid, m_axis_tready
    );
endinterface

// File: rtl/axis_fwft_fifo.sv
// First-word-fall-through FIFO; extra pointer MSB separates full from empty.
`timescale 1ns/1ps
module axis_fwft_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Head is masked while empty so stale entries never appear on the output.
    assign o_data  = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ad7386_capture_sched.sv
// Paces conversion requests for the AD7386 frame engine, buffers returned samples
// and tags the final sample of a completed burst.
`timescale 1ns/1ps
module ad7386_capture_sched
    import ad7386_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int MIN_DIV    = DEFAULT_MIN_DIV,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_start,
    input  logic                   cmd_stop,
    input  logic [CNT_W-1:0]       cfg_rate_div,
    input  logic [CNT_W-1:0]       cfg_burst_len,
    ad7386_capture_sched_if.master bus,
    output logic                   running,
    output logic                   done,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic [CNT_W-1:0]       overrun_cnt
);
    localparam logic [CNT_W-1:0] MIN_DIV_C = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_rateCnt;
    logic [CNT_W-1:0]  r_effDiv;
    logic [CNT_W-1:0]  r_burstLen;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_sampleCnt;
    logic [CNT_W-1:0]  r_overrunCnt;
    logic              r_done;

    logic [CNT_W-1:0]  w_effDiv;
    logic              w_startOk;
    logic              w_burstDone;
    logic              w_fire;
    logic              w_push;
    logic              w_pop;
    logic              w_lastTag;
    logic              w_drainOk;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W:0]   w_fifoOut;

    assign w_effDiv    = (cfg_rate_div < MIN_DIV_C) ? MIN_DIV_C : cfg_rate_div;
    assign w_startOk   = (r_state == ST_IDLE) && cmd_start && !cmd_stop;
    assign w_burstDone = (r_burstLen != '0) && (r_issued == r_burstLen);

    // A stop on the trigger cycle suppresses the request immediately, not one cycle later.
    assign w_fire      = (r_state == ST_RUN) && !cmd_stop && !w_burstDone && (r_rateCnt == '0)
                         && !bus.conv_busy && !w_full;

    assign w_push      = bus.s_axis_tvalid && !w_full;
    assign w_pop       = !w_empty && bus.m_axis_tready;
    assign w_lastTag   = (r_burstLen != '0) && ((r_sampleCnt + CNT_ONE) == r_burstLen);
    assign w_drainOk   = !bus.conv_busy && !bus.s_axis_tvalid && w_empty;

    assign bus.conv_req      = w_fire;
    assign bus.s_axis_tready = !w_full;
    assign bus.m_axis_tvalid = !w_empty;
    assign {bus.m_axis_tlast, bus.m_axis_tdata} = w_fifoOut;

    assign running     = (r_state != ST_IDLE);
    assign done        = r_done;
    assign sample_cnt  = r_sampleCnt;
    assign overrun_cnt = r_overrunCnt;

    axis_fwft_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({w_lastTag, bus.s_axis_tdata}),
        .i_pop   (w_pop),
        .o_data  (w_fifoOut),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rateCnt    <= '0;
            r_effDiv     <= MIN_DIV_C;
            r_burstLen   <= '0;
            r_issued     <= '0;
            r_overrunCnt <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_startOk) begin
                        r_state      <= ST_RUN;
                        r_effDiv     <= w_effDiv;
                        r_burstLen   <= cfg_burst_len;
                        r_rateCnt    <= '0;
                        r_issued     <= '0;
                        r_overrunCnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (cmd_stop || w_burstDone) begin
                        r_state <= ST_DRAIN;
                    end else if (r_rateCnt == '0) begin
                        // Missed slots still reload the counter so the rate grid is preserved.
                        r_rateCnt <= r_effDiv - CNT_ONE;
                        if (w_fire) begin
                            r_issued <= r_issued + CNT_ONE;
                        end else if (r_overrunCnt != '1) begin
                            r_overrunCnt <= r_overrunCnt + CNT_ONE;
                        end
                    end else begin
                        r_rateCnt <= r_rateCnt - CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (w_drainOk) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sampleCnt <= '0;
        end else if (w_startOk) begin
            r_sampleCnt <= '0;
        end else if (w_push) begin
            r_sampleCnt <= r_sampleCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ad7386_capture_sched.sv
// Directed bench for ad7386_capture_sched with an emulated frame engine and a cycle model.
`timescale 1ns/1ps
module tb_ad7386_capture_sched;

    localparam int LAT = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmdStart = 1'b0;
    logic        cmdStop = 1'b0;
    logic [15:0] cfgDiv = 16'd100;
    logic [15:0] cfgBurst = 16'd0;
    logic        running;
    logic        done;
    logic [15:0] sampleCnt;
    logic [15:0] overrunCnt;
    logic        mReady = 1'b1;
    logic        forceBusy = 1'b0;

    logic        engBusy = 1'b0;
    logic        engValid = 1'b0;
    logic [15:0] engData = 16'h0;
    logic [15:0] engSeq = 16'h0;
    int          engCnt = 0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int startCyc = 0;
    int reqLog[$];
    int outCount = 0;
    int lastCount = 0;
    int lastIdx = 0;
    int doneCount = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ad7386_capture_sched_if #(.DATA_W(16)) bus ();

    assign bus.conv_busy     = engBusy || forceBusy;
    assign bus.s_axis_tvalid = engValid;
    assign bus.s_axis_tdata  = engData;
    assign bus.m_axis_tready = mReady;

    ad7386_capture_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_start     (cmdStart),
        .cmd_stop      (cmdStop),
        .cfg_rate_div  (cfgDiv),
        .cfg_burst_len (cfgBurst),
        .bus           (bus.master),
        .running       (running),
        .done          (done),
        .sample_cnt    (sampleCnt),
        .overrun_cnt   (overrunCnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Frame engine: busy from request until its sample is accepted, sample appears LAT cycles in.
    always begin
        logic reqSeen;
        logic hs;
        @(negedge clk);
        reqSeen = bus.conv_req;
        hs = bus.s_axis_tvalid && bus.s_axis_tready;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            engBusy = 1'b0;
            engValid = 1'b0;
            engCnt = 0;
        end else begin
            if (hs) begin
                engValid = 1'b0;
                engBusy = 1'b0;
            end
            if (engBusy && !engValid) begin
                if (engCnt == 0) begin
                    engValid = 1'b1;
                    engData = 16'h1000 + engSeq * 16'h0111;
                    engSeq = engSeq + 16'd1;
                end else begin
                    engCnt--;
                end
            end
            if (reqSeen) begin
                engBusy = 1'b1;
                engCnt = LAT;
            end
        end
    end

    // Reference model: phase 0 idle, 1 triggering, 2 draining; triggers on a fixed time grid.
    logic [16:0] mQ[$];
    int mPhase = 0;
    int mT = 0;
    int mDiv = 100;
    int mBurst = 0;
    int mIssued = 0;
    int mSamples = 0;
    int mOver = 0;
    bit mDone = 1'b0;

    function automatic bit expSlot();
        return (mPhase == 1) && !(mBurst != 0 && mIssued == mBurst) && ((mT - 1) % mDiv == 0) && !cmdStop;
    endfunction

    function automatic bit expReq();
        return expSlot() && !bus.conv_busy && (mQ.size() < 4);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit push;
        bit pop;
        bit slot;
        bit req;
        bit drainOk;
        bit tag;
        if (!rst_n) begin
            mQ.delete();
            mPhase = 0;
            mT = 0;
            mIssued = 0;
            mSamples = 0;
            mOver = 0;
            mBurst = 0;
            mDone = 1'b0;
        end else begin
            slot = expSlot();
            req = expReq();
            push = bus.s_axis_tvalid && (mQ.size() < 4);
            pop = (mQ.size() > 0) && bus.m_axis_tready;
            drainOk = !bus.conv_busy && !bus.s_axis_tvalid && (mQ.size() == 0);
            tag = (mBurst != 0) && (((mSamples + 1) & 32'hFFFF) == mBurst);
            mDone = 1'b0;
            if (pop) void'(mQ.pop_front());
            if (push) begin
                mQ.push_back({tag, bus.s_axis_tdata});
                mSamples = (mSamples + 1) & 32'hFFFF;
            end
            case (mPhase)
                0: if (cmdStart && !cmdStop) begin
                    mPhase = 1;
                    mT = 1;
                    mDiv = (cfgDiv < 16'd100) ? 100 : int'(cfgDiv);
                    mBurst = int'(cfgBurst);
                    mIssued = 0;
                    mOver = 0;
                    mSamples = 0;
                end
                1: if (cmdStop || (mBurst != 0 && mIssued == mBurst)) begin
                    mPhase = 2;
                end else begin
                    if (req) mIssued++;
                    else if (slot && mOver < 65535) mOver++;
                    mT++;
                end
                default: if (drainOk) begin
                    mPhase = 0;
                    mDone = 1'b1;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model plus event logging for the directed checks.
    always @(negedge clk) begin
        logic [16:0] head;
        checkOutput("conv_req", bus.conv_req, expReq());
        checkOutput("s_axis_tready", bus.s_axis_tready, mQ.size() < 4);
        checkOutput("m_axis_tvalid", bus.m_axis_tvalid, mQ.size() > 0);
        if (mQ.size() > 0) begin
            head = mQ[0];
            checkOutput("m_axis_tdata", bus.m_axis_tdata, head[15:0]);
            checkOutput("m_axis_tlast", bus.m_axis_tlast, head[16]);
        end
        checkOutput("running", running, mPhase != 0);
        checkOutput("done", done, mDone);
        checkOutput("sample_cnt", sampleCnt, mSamples);
        checkOutput("overrun_cnt", overrunCnt, mOver);
        if (bus.conv_req) reqLog.push_back(cyc - startCyc);
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            outCount++;
            if (bus.m_axis_tlast) begin
                lastCount++;
                lastIdx = outCount;
            end
        end
        if (done) doneCount++;
    end

    task automatic applyStimulus(input logic [15:0] div, input logic [15:0] burst, input logic ready);
        cfgDiv = div;
        cfgBurst = burst;
        mReady = ready;
        @(posedge clk);
        #1;
        startCyc = cyc;
        reqLog.delete();
        outCount = 0;
        lastCount = 0;
        lastIdx = 0;
        cmdStart = 1'b1;
        @(posedge clk);
        #1;
        cmdStart = 1'b0;
        cfgDiv = 16'd7;
        cfgBurst = 16'd1;
    endtask

    task automatic waitUntilRel(input int rel);
        while ((cyc - startCyc) < rel) @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int budget);
        int n;
        int d0;
        n = 0;
        d0 = doneCount;
        while (doneCount == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("done_seen", doneCount != d0, 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0;
        @(negedge clk);
        checkOutput("rst_running", running, 0);
        checkOutput("rst_tready", bus.s_axis_tready, 1);
        checkOutput("rst_tvalid", bus.m_axis_tvalid, 0);
        checkOutput("rst_sample_cnt", sampleCnt, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] burst of 8 at div 100");
        d0 = doneCount;
        applyStimulus(16'd100, 16'd8, 1'b1);
        waitDone(2000);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t1_req_count", reqLog.size(), 8);
        foreach (reqLog[k]) checkOutput("t1_req_time", reqLog[k], 1 + 100 * k);
        checkOutput("t1_sample_cnt", sampleCnt, 8);
        checkOutput("t1_out_count", outCount, 8);
        checkOutput("t1_tlast_count", lastCount, 1);
        checkOutput("t1_tlast_index", lastIdx, 8);
        checkOutput("t1_done_once", doneCount - d0, 1);

        $display("[TB] clamp div 20 to 100");
        applyStimulus(16'd20, 16'd3, 1'b1);
        waitDone(1000);
        checkOutput("t2_req_count", reqLog.size(), 3);
        if (reqLog.size() == 3) begin
            checkOutput("t2_first", reqLog[0], 1);
            checkOutput("t2_gap1", reqLog[1] - reqLog[0], 100);
            checkOutput("t2_gap2", reqLog[2] - reqLog[1], 100);
        end
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] backpressure burst of 10");
        applyStimulus(16'd100, 16'd10, 1'b0);
        waitUntilRel(650);
        checkOutput("t3_full_tready", bus.s_axis_tready, 0);
        checkOutput("t3_overrun", overrunCnt, 3);
        checkOutput("t3_out_none", outCount, 0);
        mReady = 1'b1;
        waitDone(3000);
        checkOutput("t3_sample_cnt", sampleCnt, 10);
        checkOutput("t3_out_count", outCount, 10);
        checkOutput("t3_tlast_index", lastIdx, 10);
        checkOutput("t3_overrun_end", overrunCnt, 3);
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] busy engine window");
        applyStimulus(16'd100, 16'd6, 1'b1);
        waitUntilRel(90);
        forceBusy = 1'b1;
        waitUntilRel(340);
        forceBusy = 1'b0;
        checkOutput("t4_no_req_window", reqLog.size(), 1);
        checkOutput("t4_overrun", overrunCnt, 3);
        waitDone(2000);
        checkOutput("t4_req_count", reqLog.size(), 6);
        if (reqLog.size() > 1) checkOutput("t4_resume", reqLog[1], 401);
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] stop during continuous capture");
        applyStimulus(16'd100, 16'd0, 1'b1);
        waitUntilRel(110);
        cmdStop = 1'b1;
        @(posedge clk);
        #1;
        cmdStop = 1'b0;
        waitDone(1000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_req_count", reqLog.size(), 2);
        checkOutput("t5_out_count", outCount, 2);
        checkOutput("t5_no_tlast", lastCount, 0);
        checkOutput("t5_sample_cnt", sampleCnt, 2);
        checkOutput("t5_idle", running, 0);

        $display("[TB] start and stop together");
        cmdStart = 1'b1;
        cmdStop = 1'b1;
        @(posedge clk);
        #1;
        cmdStart = 1'b0;
        cmdStop = 1'b0;
        checkOutput("t5b_stays_idle", running, 0);

        $display("[TB] reset with samples queued");
        applyStimulus(16'd100, 16'd0, 1'b0);
        waitUntilRel(150);
        checkOutput("t6_queued", bus.m_axis_tvalid, 1);
        checkOutput("t6_sample_cnt_pre", sampleCnt, 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_running", running, 0);
        checkOutput("t6_tvalid", bus.m_axis_tvalid, 0);
        checkOutput("t6_tready", bus.s_axis_tready, 1);
        checkOutput("t6_sample_cnt", sampleCnt, 0);
        checkOutput("t6_overrun_cnt", overrunCnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mReady = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
